sha256_wk_sched: RTL and testbench



---
 rtl/sha256_wk_sched.sv | 113 +++++++++++
 tb/tb_sha256_wk_sched.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_wk_sched.sv
// SHA-256 round-word source: emits W[t]+K[t] for t=0..ROUNDS-1 from one 512-bit block; first word 1 cycle after accept.
// Valid/ready on both sides; a stalled word holds with its window, and no new block is taken until the last word leaves.
module sha256_wk_sched #(
    parameter int ROUNDS = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic [511:0] blk_data,
    output logic         wk_valid,
    input  logic         wk_ready,
    output logic [31:0]  wk,
    output logic [5:0]   wk_round,
    output logic         wk_last
);
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [5:0] LAST_T = 6'(ROUNDS - 1);

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    state_t      state_q;
    logic        blk_ready_q;
    logic        wk_valid_q;
    logic [5:0]  t_q;
    logic [31:0] w_q [16];
    logic [31:0] w_d [16];
    logic        load;
    logic        advance;

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    assign load    = (state_q == IDLE) && blk_valid;
    assign advance = wk_valid_q && wk_ready;

    always_comb begin
        for (int i = 0; i < 15; i++) begin
            w_d[i] = w_q[i + 1];
        end
        w_d[15] = sig1(w_q[14]) + w_q[9] + sig0(w_q[1]) + w_q[0];
    end

    // Window contents are irrelevant outside RUN, so they carry no reset.
    always_ff @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 16; i++) begin
                w_q[i] <= blk_data[511 - 32 * i -: 32];
            end
        end else if (advance) begin
            w_q <= w_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            blk_ready_q <= 1'b1;
            wk_valid_q  <= 1'b0;
            t_q         <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (blk_valid) begin
                        state_q     <= RUN;
                        blk_ready_q <= 1'b0;
                        wk_valid_q  <= 1'b1;
                        t_q         <= '0;
                    end
                end
                RUN: begin
                    if (advance) begin
                        if (t_q == LAST_T) begin
                            state_q     <= IDLE;
                            blk_ready_q <= 1'b1;
                            wk_valid_q  <= 1'b0;
                            t_q         <= '0;
                        end else begin
                            t_q <= t_q + 6'd1;
                        end
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    blk_ready_q <= 1'b1;
                    wk_valid_q  <= 1'b0;
                    t_q         <= '0;
                end
            endcase
        end
    end

    assign blk_ready = blk_ready_q;
    assign wk_valid  = wk_valid_q;
    assign wk_round  = t_q;
    assign wk_last   = wk_valid_q && (t_q == LAST_T);
    assign wk        = wk_valid_q ? (w_q[0] + K[t_q]) : 32'h0;
endmodule

// File: tb/tb_sha256_wk_sched.sv
// Directed bench for sha256_wk_sched: known "abc" round words, stalls, back-to-back blocks, mid-block reset, ROUNDS=16 build.
module tb_sha256_wk_sched;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         blk_valid = 1'b0;
    logic         blk_valid16 = 1'b0;
    logic         wk_ready = 1'b0;
    logic [511:0] blk_data = '0;
    logic         blk_ready, wk_valid, wk_last;
    logic         blk_ready16, wk_valid16, wk_last16;
    logic [31:0]  wk, wk16;
    logic [5:0]   wk_round, wk_round16;

    int tests = 0;
    int fails = 0;

    logic [31:0] exp_wk  [64];
    logic [31:0] got_wk  [64];
    logic [5:0]  got_rnd [64];
    logic        got_last[64];
    int          n_got;

    typedef struct {
        int          t;
        logic [31:0] wk;
    } vec_t;
    vec_t tbl [5];

    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    always #5 clk = ~clk;

    sha256_wk_sched u_dut (
        .clk       (clk),
        .rst       (rst),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .wk_valid  (wk_valid),
        .wk_ready  (wk_ready),
        .wk        (wk),
        .wk_round  (wk_round),
        .wk_last   (wk_last)
    );

    sha256_wk_sched #(.ROUNDS(16)) u_dut16 (
        .clk       (clk),
        .rst       (rst),
        .blk_valid (blk_valid16),
        .blk_ready (blk_ready16),
        .blk_data  (blk_data),
        .wk_valid  (wk_valid16),
        .wk_ready  (wk_ready),
        .wk        (wk16),
        .wk_round  (wk_round16),
        .wk_last   (wk_last16)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Reference schedule written as the textbook array recurrence.
    function automatic void build_model(input logic [511:0] d);
        logic [31:0] w [64];
        for (int i = 0; i < 16; i++) w[i] = d[511 - 32 * i -: 32];
        for (int i = 16; i < 64; i++)
            w[i] = (ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
                 + (ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
        for (int i = 0; i < 64; i++) exp_wk[i] = w[i] + KT[i];
    endfunction

    // Called at a negedge; returns at the negedge just after the accept edge.
    task automatic accept_block(input logic [511:0] d, input bit hold);
        int cyc = 0;
        blk_data  = d;
        blk_valid = 1'b1;
        while (!blk_ready && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        chk("accept timeout", 32'(cyc < 500), 32'd1);
        @(negedge clk);
        if (!hold) blk_valid = 1'b0;
        chk("first wk_valid latency", 32'(wk_valid), 32'd1);
        chk("first wk_round", 32'(wk_round), 32'd0);
    endtask

    // mode 0: always ready; mode 1: random stalls plus a 5-cycle hold at t=16.
    task automatic collect(input int mode, input int take);
        int   cyc = 0;
        int   hold = 0;
        bit   stalled = 1'b0;
        bit   r;
        bit   ready_seen = 1'b0;
        logic [31:0] pw = '0;
        logic [5:0]  pr = '0;
        n_got = 0;
        while (n_got < take && cyc < 3000) begin
            if (wk_valid) begin
                if (blk_ready) ready_seen = 1'b1;
                if (stalled) begin
                    chk("stall wk stable", wk, pw);
                    chk("stall round stable", 32'(wk_round), 32'(pr));
                end
                if (mode == 0) r = 1'b1;
                else if (wk_round == 6'd16 && hold < 5) begin
                    r = 1'b0;
                    hold++;
                end else r = ($urandom_range(0, 2) != 0);
                wk_ready = r;
                if (r) begin
                    got_wk[n_got]   = wk;
                    got_rnd[n_got]  = wk_round;
                    got_last[n_got] = wk_last;
                    n_got++;
                end
                stalled = !r;
                pw = wk;
                pr = wk_round;
            end
            @(negedge clk);
            cyc++;
        end
        chk("collect word count", 32'(n_got), 32'(take));
        chk("blk_ready low while running", 32'(ready_seen), 32'd0);
        if (mode == 1) chk("t=16 hold applied", 32'(hold), 32'd5);
    endtask

    task automatic check_run(input string name);
        for (int i = 0; i < 64; i++) begin
            chk($sformatf("%s wk[%0d]", name, i), got_wk[i], exp_wk[i]);
            chk($sformatf("%s round[%0d]", name, i), 32'(got_rnd[i]), 32'(i));
            chk($sformatf("%s last[%0d]", name, i), 32'(got_last[i]), 32'(i == 63));
        end
    endtask

    task automatic done_chk(input string name);
        chk({name, " idle wk_valid"}, 32'(wk_valid), 32'd0);
        chk({name, " idle blk_ready"}, 32'(blk_ready), 32'd1);
        chk({name, " idle wk"}, wk, 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [511:0] abc;
        logic [511:0] blk_b;
        logic [511:0] blk_c;
        bit           spurious;
        int           cyc;

        abc = {32'h61626380, 448'b0, 32'h00000018};
        for (int i = 0; i < 16; i++) begin
            blk_b[511 - 32 * i -: 32] = 32'h01234567 * (i + 1);
            blk_c[511 - 32 * i -: 32] = 32'hdeadbeef ^ (32'h11111111 * i);
        end
        tbl[0] = '{0,  32'hA3EC9318};
        tbl[1] = '{15, 32'hC19BF18C};
        tbl[2] = '{16, 32'h45FDCD41};
        tbl[3] = '{17, 32'hEFCD4786};
        tbl[4] = '{1,  32'h71374491};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset blk_ready", 32'(blk_ready), 32'd1);
        chk("reset wk_valid", 32'(wk_valid), 32'd0);
        chk("reset wk_round", 32'(wk_round), 32'd0);
        chk("reset wk_last", 32'(wk_last), 32'd0);
        chk("reset wk", wk, 32'd0);
        chk("reset blk_ready16", 32'(blk_ready16), 32'd1);
        rst = 1'b0;
        spurious = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wk_ready = 1'b1;
            if (wk_valid || wk_valid16) spurious = 1'b1;
            @(negedge clk);
        end
        chk("no wk_valid without block", 32'(spurious), 32'd0);

        build_model(abc);
        accept_block(abc, 1'b0);
        collect(0, 64);
        for (int i = 0; i < 5; i++)
            chk($sformatf("abc table t=%0d", tbl[i].t), got_wk[tbl[i].t], tbl[i].wk);
        check_run("abc");
        done_chk("abc");

        accept_block(abc, 1'b0);
        collect(1, 64);
        check_run("stall");
        done_chk("stall");

        accept_block(abc, 1'b1);
        blk_data = blk_b;
        collect(0, 64);
        check_run("b2b first");
        done_chk("b2b first");
        build_model(blk_b);
        @(negedge clk);
        blk_valid = 1'b0;
        chk("b2b second valid", 32'(wk_valid), 32'd1);
        chk("b2b second round", 32'(wk_round), 32'd0);
        chk("b2b second wk0", wk, exp_wk[0]);
        collect(0, 64);
        check_run("b2b second");
        done_chk("b2b second");

        build_model(abc);
        accept_block(abc, 1'b0);
        collect(0, 30);
        chk("pre-reset round", 32'(wk_round), 32'd30);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        done_chk("mid reset");
        spurious = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (wk_valid) spurious = 1'b1;
            @(negedge clk);
        end
        chk("no wk_valid after reset", 32'(spurious), 32'd0);
        build_model(blk_c);
        accept_block(blk_c, 1'b0);
        collect(0, 64);
        check_run("post reset");
        done_chk("post reset");

        build_model(abc);
        blk_data    = abc;
        blk_valid16 = 1'b1;
        wk_ready    = 1'b1;
        cyc = 0;
        while (!blk_ready16 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        @(negedge clk);
        blk_valid16 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("r16 valid[%0d]", i), 32'(wk_valid16), 32'd1);
            chk($sformatf("r16 round[%0d]", i), 32'(wk_round16), 32'(i));
            chk($sformatf("r16 wk[%0d]", i), wk16, exp_wk[i]);
            chk($sformatf("r16 last[%0d]", i), 32'(wk_last16), 32'(i == 15));
            if (i == 15) chk("r16 final wk", wk16, 32'hC19BF18C);
            @(negedge clk);
        end
        chk("r16 idle wk_valid", 32'(wk_valid16), 32'd0);
        chk("r16 idle blk_ready", 32'(blk_ready16), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
